// File: rtl/gbf_pingpong.sv
// rtl/gbf_pingpong.sv - two-bank ping-pong global buffer with fill/release handshake
//
// Ports:
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   fill_len       words per fill, sampled on the first beat of a fill (0 or >DEPTH -> DEPTH)
//   wr_valid       producer offers wr_data
//   wr_ready       bank being filled is not full (a beat is accepted)
//   wr_data        write word
//   wr_bank        index of bank currently being filled
//   rd_ready       current read bank is full and owned by the consumer
//   rd_bank        index of current read bank
//   rd_en, rd_addr read request into the read bank, data returned one cycle later
//   rd_data        read word (holds its value when no read is served)
//   rd_data_valid  rd_data carries a newly read word this cycle
//   rd_release     consumer hands the read bank back to the producer
//   full_cnt       number of banks currently full (0..2)
module gbf_pingpong #(
  parameter int DATA_BITWIDTH = 512,
  parameter int ADDR_BITWIDTH = 5,
  parameter int DEPTH         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_BITWIDTH:0]   fill_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_BITWIDTH-1:0] wr_data,
  output logic                     wr_bank,
  output logic                     rd_ready,
  output logic                     rd_bank,
  input  logic                     rd_en,
  input  logic [ADDR_BITWIDTH-1:0] rd_addr,
  output logic [DATA_BITWIDTH-1:0] rd_data,
  output logic                     rd_data_valid,
  input  logic                     rd_release,
  output logic [1:0]               full_cnt
);

  localparam logic [ADDR_BITWIDTH:0] DEPTH_W = (ADDR_BITWIDTH + 1)'(DEPTH);
  localparam logic [ADDR_BITWIDTH:0] ONE_W   = (ADDR_BITWIDTH + 1)'(1);

  logic                     wb;
  logic                     rb;
  logic [1:0]               full;
  logic [1:0]               full_nxt;
  logic [ADDR_BITWIDTH:0]   wcnt;
  logic [ADDR_BITWIDTH:0]   len_q;
  logic [ADDR_BITWIDTH:0]   len_first;
  logic [ADDR_BITWIDTH:0]   len_cur;
  logic                     beat;
  logic                     last_beat;
  logic                     release_ok;
  logic                     read_ok;

  logic [DATA_BITWIDTH-1:0] mem [2][DEPTH];

  assign wr_ready = !full[wb];
  assign rd_ready = full[rb];
  assign wr_bank  = wb;
  assign rd_bank  = rb;
  assign full_cnt = {1'b0, full[0]} + {1'b0, full[1]};

  always_comb begin
    beat       = wr_valid && wr_ready;
    len_first  = (fill_len == '0 || fill_len > DEPTH_W) ? DEPTH_W : fill_len;
    // The first beat of a fill uses the live fill_len; later beats use the latched length.
    len_cur    = (wcnt == '0) ? len_first : len_q;
    last_beat  = beat && (wcnt == (len_cur - ONE_W));
    release_ok = rd_release && full[rb];
    read_ok    = rd_en && full[rb];
    // Filling targets a non-full bank and release targets a full one, so the two
    // updates below never touch the same bit and both survive a shared cycle.
    full_nxt = full;
    if (last_beat) begin
      full_nxt[wb] = 1'b1;
    end
    if (release_ok) begin
      full_nxt[rb] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb            <= 1'b0;
      rb            <= 1'b0;
      full          <= 2'b00;
      wcnt          <= '0;
      len_q         <= DEPTH_W;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      if (beat) begin
        if (wcnt == '0) begin
          len_q <= len_first;
        end
        if (last_beat) begin
          wcnt <= '0;
          wb   <= ~wb;
        end else begin
          wcnt <= wcnt + ONE_W;
        end
      end
      full <= full_nxt;
      if (release_ok) begin
        rb <= ~rb;
      end
      // A read issued together with a release is served from the bank being released.
      rd_data_valid <= read_ok;
      if (read_ok) begin
        rd_data <= mem[rb][rd_addr];
      end
    end
  end

  // Storage is never cleared; a beat in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && beat) begin
      mem[wb][wcnt[ADDR_BITWIDTH-1:0]] <= wr_data;
    end
  end

endmodule

// File: doc/gbf_pingpong.md
GBF_PINGPONG -- requirements
Module: gbf_pingpong

Interface
REQ-001: Parameter DATA_BITWIDTH, default 512, word width of both banks.
REQ-002: Parameter ADDR_BITWIDTH, default 5, address width of each bank.
REQ-003: Parameter DEPTH, default 32, words per bank (DEPTH <= 2^ADDR_BITWIDTH).
REQ-004: clk  input  1  single clock; all logic on rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: fill_len  input  ADDR_BITWIDTH+1  words per fill, sampled on first write beat of each fill.
REQ-007: wr_valid  input  1  producer has a word.
REQ-008: wr_ready  output  1  block accepts a word this cycle.
REQ-009: wr_data  input  DATA_BITWIDTH  write word.
REQ-010: wr_bank  output  1  index of bank currently being filled.
REQ-011: rd_ready  output  1  current read bank is full and owned by consumer.
REQ-012: rd_bank  output  1  index of current read bank.
REQ-013: rd_en  input  1  read request.
REQ-014: rd_addr  input  ADDR_BITWIDTH  read address within read bank.
REQ-015: rd_data  output  DATA_BITWIDTH  read word.
REQ-016: rd_data_valid  output  1  rd_data holds a new word this cycle.
REQ-017: rd_release  input  1  consumer done with read bank.
REQ-018: full_cnt  output  2  number of banks in FULL state (0..2).

Function
REQ-019: Two banks of DEPTH x DATA_BITWIDTH storage; each bank carries a full flag; write pointer wb drives wr_bank, read pointer rb drives rd_bank.
REQ-020: wr_ready SHALL equal !full[wb] (combinational, registered state only).
REQ-021: Beat = wr_valid && wr_ready; beat writes wr_data to bank wb at address wcnt, wcnt increments.
REQ-022: On first beat of a fill (wcnt==0) effective length L = fill_len, clamped: fill_len==0 or fill_len>DEPTH -> L=DEPTH; L latched for the rest of the fill.
REQ-023: On beat with wcnt==L-1: full[wb] set, wb toggles, wcnt cleared, same edge; L==1 completes a fill in one beat.
REQ-024: Back-to-back fills: if the other bank is empty, wr_ready stays high across the bank switch with no bubble cycle.
REQ-025: rd_ready SHALL equal full[rb].
REQ-026: rd_en && rd_ready: rd_data = bank rb[rd_addr] and rd_data_valid = 1 exactly one cycle later (1-cycle latency); reads may issue every cycle.
REQ-027: rd_en while !rd_ready: ignored, rd_data_valid = 0 next cycle, rd_data holds previous value.
REQ-028: rd_addr beyond L of that fill: returns stored (stale) contents, no error indication.
REQ-029: rd_release && rd_ready: full[rb] cleared, rb toggles; rd_release while !rd_ready ignored.
REQ-030: rd_en and rd_release in same cycle: read served from the releasing bank, then release takes effect.
REQ-031: Fill completion and release in the same cycle act on different banks and SHALL both take effect; full_cnt reflects both.
REQ-032: full_cnt = full[0] + full[1], registered-state derived.
REQ-033: Write and read of the same bank at the same time is impossible by construction (wb bank never full, rb bank always full while readable).

Reset
REQ-034: rst high at a clock edge: wb=0, rb=0, full=00, wcnt=0, L=DEPTH, rd_data=0, rd_data_valid=0; hence wr_ready=1, rd_ready=0, full_cnt=0 on the following cycle.
REQ-035: rst has priority over all inputs in that cycle; partial fill and held bank are discarded; bank storage contents are not cleared.

Verification
REQ-036: Reset, then fill_len=4, 4 beats 0xA0..0xA3 -> full_cnt=1, rd_ready=1, rd_bank=0, wr_bank=1, wr_ready=1; rd_en addr 2 -> rd_data=0xA2, rd_data_valid=1 one cycle later.
REQ-037: Fill both banks (fill_len=4) without release -> wr_ready=0, full_cnt=2; further wr_valid not written; rd_release -> next cycle wr_ready=1, rd_bank=1, full_cnt=1.
REQ-038: fill_len=0 -> fill completes after exactly 32 beats; fill_len=40 -> 32 beats; fill_len=1 -> 1 beat.
REQ-039: Same-cycle 4th beat of bank 1 and rd_release of bank 0 -> full_cnt stays 1, rd_bank=1, wr_bank=0, wr_ready=1.
REQ-040: rd_en with rd_ready=0 -> rd_data_valid=0, rd_data unchanged; rd_en + rd_release same cycle -> old-bank data returned, rd_bank toggles.
REQ-041: rst asserted after 2 of 4 beats with one bank full -> next cycle full_cnt=0, wr_bank=0, rd_ready=0, wr_ready=1; new fill of 4 beats needed for rd_ready.
